// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scan driver: time-slots one digit at a time with a dark lead-in,
// per-digit masking, 16-level PWM brightness, selectable output polarity and a frame tick.
module seg_scan_mux #(
    parameter int NUM_DIGITS     = 8,
    parameter int SEG_W          = 7,
    parameter int PRESCALE       = 1024,
    parameter int BLANK_CYC      = 16,
    parameter int EN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                        clk,
    input  logic                        rst_x,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]       digit_mask,
    input  logic [3:0]                  brightness,
    output logic [SEG_W-1:0]            seg_display,
    output logic [NUM_DIGITS-1:0]       array_en,
    output logic                        frame_tick
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int LOC_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [LOC_W-1:0]      LOC_MAX   = LOC_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] EN_OFF    = (EN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [SEG_W-1:0]      SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : '0;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LOC_W-1:0]      scan_loc_q, scan_loc_d;
    logic [SEG_W-1:0]      shadow_seg_q, shadow_seg_d;
    logic                  shadow_mask_q, shadow_mask_d;
    logic [3:0]            shadow_bright_q, shadow_bright_d;
    logic [SEG_W-1:0]      seg_display_q, seg_display_d;
    logic [NUM_DIGITS-1:0] array_en_q, array_en_d;
    logic                  frame_tick_q, frame_tick_d;

    logic [SEG_W-1:0]      digit_pat [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] onehot;
    logic                  slot_end;
    logic                  last_digit;
    logic                  lit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_pat[gi] = seg_in[gi*SEG_W +: SEG_W];
        end
    endgenerate

    always_comb begin
        slot_end   = (cnt_q == CNT_MAX);
        last_digit = (scan_loc_q == LOC_MAX);

        cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
        scan_loc_d = scan_loc_q;
        if (slot_end) begin
            scan_loc_d = last_digit ? '0 : scan_loc_q + 1'b1;
        end

        // Inputs are frozen for the whole slot so a mid-slot change cannot tear the digit.
        shadow_seg_d    = shadow_seg_q;
        shadow_mask_d   = shadow_mask_q;
        shadow_bright_d = shadow_bright_q;
        if (cnt_q == '0) begin
            shadow_seg_d    = digit_pat[scan_loc_q];
            shadow_mask_d   = digit_mask[scan_loc_q];
            shadow_bright_d = brightness;
        end

        // The shadow is stale at cnt==0, which is harmless because cnt==0 is always blanked.
        lit = (cnt_q >= BLANK_END) && shadow_mask_q && (cnt_q[3:0] <= shadow_bright_q);

        onehot             = '0;
        onehot[scan_loc_q] = 1'b1;

        array_en_d    = lit ? (onehot ^ EN_OFF) : EN_OFF;
        seg_display_d = lit ? (shadow_seg_q ^ SEG_OFF) : SEG_OFF;
        frame_tick_d  = slot_end && last_digit;
    end

    always_ff @(posedge clk) begin
        if (!rst_x) begin
            cnt_q           <= '0;
            scan_loc_q      <= '0;
            shadow_seg_q    <= '0;
            shadow_mask_q   <= 1'b0;
            shadow_bright_q <= '0;
            seg_display_q   <= SEG_OFF;
            array_en_q      <= EN_OFF;
            frame_tick_q    <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            scan_loc_q      <= scan_loc_d;
            shadow_seg_q    <= shadow_seg_d;
            shadow_mask_q   <= shadow_mask_d;
            shadow_bright_q <= shadow_bright_d;
            seg_display_q   <= seg_display_d;
            array_en_q      <= array_en_d;
            frame_tick_q    <= frame_tick_d;
        end
    end

    assign seg_display = seg_display_q;
    assign array_en    = array_en_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: directed vector table, hand-written corner
// sequences, and randomized inputs checked every cycle against a cycle-count reference model.
module tb_seg_scan_mux;

    localparam int N = 4;
    localparam int W = 7;
    localparam int P = 32;
    localparam int B = 4;

    logic           clk;
    logic           rst_x;
    logic [N*W-1:0] seg_in;
    logic [N-1:0]   digit_mask;
    logic [3:0]     brightness;
    logic [W-1:0]   seg_display;
    logic [N-1:0]   array_en;
    logic           frame_tick;

    seg_scan_mux #(
        .NUM_DIGITS    (N),
        .SEG_W         (W),
        .PRESCALE      (P),
        .BLANK_CYC     (B),
        .EN_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW(0)
    ) dut (
        .clk        (clk),
        .rst_x      (rst_x),
        .seg_in     (seg_in),
        .digit_mask (digit_mask),
        .brightness (brightness),
        .seg_display(seg_display),
        .array_en   (array_en),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: c counts cycles since reset release; everything is derived from it.
    int           c      = 0;
    int           last_c = -1;
    logic [W-1:0] m_seg;
    logic         m_mask;
    logic [3:0]   m_br;
    logic [N-1:0] exp_en;
    logic [W-1:0] exp_seg;
    logic         exp_tick;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] br;
        int         cyc;
        logic [3:0] en;
        logic [6:0] seg;
        logic       tick;
    } vec_t;

    vec_t tbl[$];

    localparam logic [N*W-1:0] BASE_PAT = {7'h08, 7'h04, 7'h02, 7'h01};

    task automatic check(input string name, input int cyc, input logic [N-1:0] en,
                         input logic [W-1:0] seg, input logic tk);
        n_cmp++;
        if (array_en !== en || seg_display !== seg || frame_tick !== tk) begin
            n_fail++;
            $display("FAIL %s (c=%0d): got en=%b seg=%h tick=%b, want en=%b seg=%h tick=%b",
                     name, cyc, array_en, seg_display, frame_tick, en, seg, tk);
        end
    endtask

    task automatic step();
        int slot;
        int k;
        bit lit;
        @(posedge clk);
        if (!rst_x) begin
            c        = 0;
            last_c   = -1;
            m_seg    = '0;
            m_mask   = 1'b0;
            m_br     = '0;
            exp_en   = '1;
            exp_seg  = '0;
            exp_tick = 1'b0;
        end else begin
            slot = (c / P) % N;
            k    = c % P;
            if (k == 0) begin
                m_seg  = seg_in[slot*W +: W];
                m_mask = digit_mask[slot];
                m_br   = brightness;
            end
            lit      = (k >= B) && m_mask && ((k % 16) <= int'(m_br));
            exp_en   = '1;
            if (lit) exp_en[slot] = 1'b0;
            exp_seg  = lit ? m_seg : '0;
            exp_tick = ((c % (N * P)) == (N * P - 1));
            last_c   = c;
            c++;
        end
        #1;
        check("model", last_c, exp_en, exp_seg, exp_tick);
    endtask

    task automatic do_reset(input int n);
        rst_x = 1'b0;
        repeat (n) step();
        rst_x = 1'b1;
    endtask

    task automatic go_to(input int t);
        int g = 0;
        while (last_c != t && g < 400) begin
            step();
            g++;
        end
        n_cmp++;
        if (last_c != t) begin
            n_fail++;
            $display("FAIL go_to: reached c=%0d, want c=%0d", last_c, t);
        end
    endtask

    initial begin
        rst_x      = 1'b0;
        seg_in     = BASE_PAT;
        digit_mask = 4'hF;
        brightness = 4'd15;

        // Reset held for 3 clocks: everything inactive.
        repeat (3) begin
            step();
            check("reset_hold", last_c, 4'b1111, 7'h00, 1'b0);
        end
        rst_x = 1'b1;

        tbl.push_back('{4'hF, 4'd15,   0, 4'b1111, 7'h00, 1'b0});
        tbl.push_back('{4'hF, 4'd15,   3, 4'b1111, 7'h00, 1'b0});
        tbl.push_back('{4'hF, 4'd15,   4, 4'b1110, 7'h01, 1'b0});
        tbl.push_back('{4'hF, 4'd15,  31, 4'b1110, 7'h01, 1'b0});
        tbl.push_back('{4'hF, 4'd15,  32, 4'b1111, 7'h00, 1'b0});
        tbl.push_back('{4'hF, 4'd15,  36, 4'b1101, 7'h02, 1'b0});
        tbl.push_back('{4'hF, 4'd15,  68, 4'b1011, 7'h04, 1'b0});
        tbl.push_back('{4'hF, 4'd15, 100, 4'b0111, 7'h08, 1'b0});
        tbl.push_back('{4'hF, 4'd15, 126, 4'b0111, 7'h08, 1'b0});
        tbl.push_back('{4'hF, 4'd15, 127, 4'b0111, 7'h08, 1'b1});
        tbl.push_back('{4'hF, 4'd15, 128, 4'b1111, 7'h00, 1'b0});
        tbl.push_back('{4'hF, 4'd3,   15, 4'b1111, 7'h00, 1'b0});
        tbl.push_back('{4'hF, 4'd3,   16, 4'b1110, 7'h01, 1'b0});
        tbl.push_back('{4'hF, 4'd3,   19, 4'b1110, 7'h01, 1'b0});
        tbl.push_back('{4'hF, 4'd3,   20, 4'b1111, 7'h00, 1'b0});
        tbl.push_back('{4'hF, 4'd3,    8, 4'b1111, 7'h00, 1'b0});
        tbl.push_back('{4'hF, 4'd0,   16, 4'b1110, 7'h01, 1'b0});
        tbl.push_back('{4'hF, 4'd0,   17, 4'b1111, 7'h00, 1'b0});
        tbl.push_back('{4'hA, 4'd15,  10, 4'b1111, 7'h00, 1'b0});
        tbl.push_back('{4'hA, 4'd15,  40, 4'b1101, 7'h02, 1'b0});
        tbl.push_back('{4'hA, 4'd15,  72, 4'b1111, 7'h00, 1'b0});
        tbl.push_back('{4'hA, 4'd15, 104, 4'b0111, 7'h08, 1'b0});
        tbl.push_back('{4'hA, 4'd15, 127, 4'b0111, 7'h08, 1'b1});

        foreach (tbl[i]) begin
            seg_in     = BASE_PAT;
            digit_mask = tbl[i].mask;
            brightness = tbl[i].br;
            do_reset(2);
            go_to(tbl[i].cyc);
            check($sformatf("vec%0d", i), last_c, tbl[i].en, tbl[i].seg, tbl[i].tick);
        end

        // Mid-slot pattern change: old pattern held, new one shown next frame.
        seg_in     = BASE_PAT;
        digit_mask = 4'hF;
        brightness = 4'd15;
        do_reset(2);
        go_to(41);
        seg_in[13:7] = 7'h55;
        go_to(50);
        check("midslot_old", last_c, 4'b1101, 7'h02, 1'b0);
        go_to(63);
        check("midslot_end", last_c, 4'b1101, 7'h02, 1'b0);
        go_to(164);
        check("midslot_new", last_c, 4'b1101, 7'h55, 1'b0);

        // One-cycle reset at cnt=20 of slot 2, then a clean restart at slot 0.
        seg_in = BASE_PAT;
        do_reset(2);
        go_to(83);
        check("pre_rst", last_c, 4'b1011, 7'h04, 1'b0);
        rst_x = 1'b0;
        step();
        check("mid_rst", last_c, 4'b1111, 7'h00, 1'b0);
        rst_x = 1'b1;
        go_to(0);
        check("restart_c0", last_c, 4'b1111, 7'h00, 1'b0);
        go_to(3);
        check("restart_c3", last_c, 4'b1111, 7'h00, 1'b0);
        go_to(4);
        check("restart_c4", last_c, 4'b1110, 7'h01, 1'b0);

        // Randomized inputs, checked every cycle by the model inside step().
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) seg_in = {$urandom, $urandom};
            if ($urandom_range(0, 39) == 0) digit_mask = 4'($urandom);
            if ($urandom_range(0, 29) == 0) brightness = 4'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
